// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//
// Shares the single plot port of the VGA adapter between NUM_REQ independent
// draw engines. An engine owns the port for the whole of a draw job, from its
// request until its done pulse. Engines are picked in round-robin order, and
// only the owner's pixel stream is forwarded to the adapter.
//
// Ports
//   clk, reset      system clock; asynchronous active-high reset
//   req             per-engine request, held high for the whole job
//   req_done        per-engine one-cycle pulse on the last pixel of the job
//   req_x/y/colour  packed per-engine pixel data, engine i at [i*W +: W]
//   req_plot        per-engine plot strobe
//   grant           one-hot ownership, all zero when free
//   x, y, colour    pixel to the VGA adapter
//   writeEn         plot strobe to the VGA adapter
//   busy            high while a grant is active
//   owner           index of the current or most recent owner
//   timeout         sticky flag, set when a grant is force-released
module vga_draw_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 8,
    parameter int MAX_HOLD = 19200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_done,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    input  logic [NUM_REQ-1:0]     req_plot,
    output logic [NUM_REQ-1:0]     grant,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   writeEn,
    output logic                   busy,
    output logic [1:0]             owner,
    output logic                   timeout
);

    localparam int IDX_W  = (NUM_REQ > 2) ? 2 : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IDX_W:0]    NREQ_L   = (IDX_W + 1)'(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   owner_idx;
    logic [HOLD_W-1:0]  hold_cnt;

    // (a + b) mod NUM_REQ for indices already below NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= NREQ_L)
            sum = sum - NREQ_L;
        return IDX_W'(sum);
    endfunction

    // Round-robin pick: req_rot[k] is the request of engine (rr + k) mod
    // NUM_REQ; the chain resolves to the lowest k with a request, so the
    // search order is rr, rr+1, ... wrapping around.
    logic [NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]   pick_chain [NUM_REQ+1];
    logic [IDX_W-1:0]   pick_idx;

    assign pick_chain[NUM_REQ] = '0;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rot
        assign req_rot[k]    = |(req & (NUM_REQ'(1) << wrap_add(rr, IDX_W'(k))));
        assign pick_chain[k] = req_rot[k] ? IDX_W'(k) : pick_chain[k+1];
    end

    assign pick_idx = wrap_add(rr, pick_chain[0]);

    // Owner's pixel slice, selected by the one-hot grant (zero when no grant).
    logic [X_W-1:0] x_acc [NUM_REQ+1];
    logic [Y_W-1:0] y_acc [NUM_REQ+1];
    logic [C_W-1:0] c_acc [NUM_REQ+1];

    assign x_acc[0] = '0;
    assign y_acc[0] = '0;
    assign c_acc[0] = '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mux
        assign x_acc[i+1] = x_acc[i] | ({X_W{grant[i]}} & req_x[i*X_W +: X_W]);
        assign y_acc[i+1] = y_acc[i] | ({Y_W{grant[i]}} & req_y[i*Y_W +: Y_W]);
        assign c_acc[i+1] = c_acc[i] | ({C_W{grant[i]}} & req_colour[i*C_W +: C_W]);
    end

    // Owner's control lines; non-owners are masked out by the grant.
    logic own_req;
    logic own_done;
    logic own_plot;
    logic hold_hit;

    assign own_req  = |(req & grant);
    assign own_done = |(req_done & grant);
    assign own_plot = |(req_plot & grant);
    assign hold_hit = (hold_cnt == HOLD_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            owner_idx <= '0;
            timeout   <= 1'b0;
            rr        <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= NUM_REQ'(1) << pick_idx;
                        owner_idx <= pick_idx;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    // Done, abort and hold expiry all collapse into one release.
                    if (own_done || !own_req || hold_hit) begin
                        grant    <= '0;
                        busy     <= 1'b0;
                        rr       <= wrap_add(owner_idx, IDX_W'(1));
                        hold_cnt <= '0;
                        if (hold_hit)
                            timeout <= 1'b1;
                        state    <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pixel path is combinational from registered state, so an async reset
    // drops writeEn immediately; an aborting owner (req low) cannot plot.
    always_comb begin
        x       = '0;
        y       = '0;
        colour  = '0;
        writeEn = 1'b0;
        if (state == OWN) begin
            x       = x_acc[NUM_REQ];
            y       = y_acc[NUM_REQ];
            colour  = c_acc[NUM_REQ];
            writeEn = own_plot & own_req;
        end
    end

    assign owner = 2'(owner_idx);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed testbench for vga_draw_arbiter (NUM_REQ=3, MAX_HOLD=16).
module tb_vga_draw_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_done;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [23:0] req_colour;
    logic [2:0]  req_plot;
    logic [2:0]  grant;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [7:0]  colour;
    logic        writeEn;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    vga_draw_arbiter #(
        .NUM_REQ (3),
        .X_W     (8),
        .Y_W     (7),
        .C_W     (8),
        .MAX_HOLD(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_done  (req_done),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_colour(req_colour),
        .req_plot  (req_plot),
        .grant     (grant),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy),
        .owner     (owner),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int i, input logic [7:0] xv, input logic [6:0] yv,
                           input logic [7:0] cv);
        req_x[i*8 +: 8]      = xv;
        req_y[i*7 +: 7]      = yv;
        req_colour[i*8 +: 8] = cv;
    endtask

    logic [2:0] rr_seq [4];

    initial begin
        rr_seq     = '{3'b001, 3'b010, 3'b100, 3'b001};
        reset      = 1'b1;
        req        = '0;
        req_done   = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        req_plot   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_wen", 32'(writeEn), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        reset = 1'b0;

        // Single request on engine 1
        tick();
        req = 3'b010;
        #1;
        chk("single_pre_grant", 32'(grant), 32'd0);
        tick();
        chk("single_grant", 32'(grant), 32'b010);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_owner", 32'(owner), 32'd1);
        set_pix(1, 8'd10, 7'd20, 8'hE0);
        req_plot = 3'b010;
        #1;
        chk("single_x", 32'(x), 32'd10);
        chk("single_y", 32'(y), 32'd20);
        chk("single_colour", 32'(colour), 32'hE0);
        chk("single_wen", 32'(writeEn), 32'd1);
        tick();
        tick();
        req_done = 3'b010;
        #1;
        chk("single_done_cycle_wen", 32'(writeEn), 32'd1);
        tick();
        req_done = '0;
        req      = '0;
        req_plot = '0;
        #1;
        chk("single_release_grant", 32'(grant), 32'd0);
        chk("single_release_busy", 32'(busy), 32'd0);
        chk("single_release_wen", 32'(writeEn), 32'd0);
        chk("single_release_x", 32'(x), 32'd0);
        tick();
        chk("single_idle_owner", 32'(owner), 32'd1);
        chk("single_idle_grant", 32'(grant), 32'd0);

        // Round robin with all engines requesting; pointer restarted by reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req   = 3'b111;
        tick();
        for (int j = 0; j < 4; j++) begin
            chk("rr_grant", 32'(grant), 32'(rr_seq[j]));
            tick();
            tick();
            tick();
            req_done = rr_seq[j];
            tick();
            req_done = '0;
            if (j == 3)
                req = '0;
            #1;
            chk("rr_release_gap", 32'(grant), 32'd0);
            tick();
            chk("rr_idle_gap", 32'(grant), 32'd0);
            if (j < 3)
                tick();
        end

        // Isolation: owner 0 not plotting, engine 2 plotting while waiting
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req   = 3'b101;
        tick();
        chk("iso_grant", 32'(grant), 32'b001);
        set_pix(0, 8'd0, 7'd0, 8'h00);
        set_pix(2, 8'd99, 7'd5, 8'h1C);
        req_plot = 3'b100;
        #1;
        chk("iso_wen", 32'(writeEn), 32'd0);
        chk("iso_x", 32'(x), 32'd0);
        tick();
        chk("iso_grant_hold", 32'(grant), 32'b001);
        req_done = 3'b100;
        tick();
        req_done = '0;
        #1;
        chk("iso_foreign_done_grant", 32'(grant), 32'b001);
        chk("iso_foreign_done_busy", 32'(busy), 32'd1);
        req_done = 3'b001;
        req      = 3'b100;
        tick();
        req_done = '0;
        #1;
        chk("iso_release", 32'(grant), 32'd0);
        tick();
        tick();
        chk("iso_next_grant", 32'(grant), 32'b100);
        chk("iso_next_owner", 32'(owner), 32'd2);

        // Abort: owner 2 drops req, engine 0 waiting
        chk("abort_pre_wen", 32'(writeEn), 32'd1);
        chk("abort_pre_x", 32'(x), 32'd99);
        req = 3'b001;
        #1;
        chk("abort_wen", 32'(writeEn), 32'd0);
        tick();
        req_plot = '0;
        #1;
        chk("abort_release", 32'(grant), 32'd0);
        tick();
        chk("abort_idle", 32'(grant), 32'd0);
        tick();
        chk("abort_next_grant", 32'(grant), 32'b001);
        req_done = 3'b001;
        req      = '0;
        tick();
        req_done = '0;
        #1;
        chk("abort_job0_release", 32'(grant), 32'd0);

        // Timeout: engine 1 holds without done
        req = 3'b010;
        tick();
        tick();
        chk("to_grant", 32'(grant), 32'b010);
        chk("to_flag_clear", 32'(timeout), 32'd0);
        for (int j = 0; j < 15; j++)
            tick();
        chk("to_still_held", 32'(grant), 32'b010);
        chk("to_not_yet", 32'(timeout), 32'd0);
        tick();
        chk("to_forced_release", 32'(grant), 32'd0);
        chk("to_flag_set", 32'(timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        req = 3'b100;
        tick();
        tick();
        chk("to_next_grant", 32'(grant), 32'b100);
        chk("to_sticky_in_job", 32'(timeout), 32'd1);
        req_done = 3'b100;
        req      = '0;
        tick();
        req_done = '0;
        #1;
        chk("to_job_release", 32'(grant), 32'd0);
        chk("to_sticky_after", 32'(timeout), 32'd1);

        // Async reset mid-job
        req      = 3'b010;
        req_plot = 3'b010;
        set_pix(1, 8'd10, 7'd20, 8'hE0);
        tick();
        tick();
        chk("ar_grant", 32'(grant), 32'b010);
        chk("ar_wen", 32'(writeEn), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_grant_async", 32'(grant), 32'd0);
        chk("ar_wen_async", 32'(writeEn), 32'd0);
        chk("ar_busy_async", 32'(busy), 32'd0);
        chk("ar_timeout_cleared", 32'(timeout), 32'd0);
        reset    = 1'b0;
        req      = 3'b100;
        req_plot = '0;
        tick();
        chk("ar_regrant", 32'(grant), 32'b100);
        chk("ar_regrant_owner", 32'(owner), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single plot port of the VGA adapter (x, y, colour, writeEn) between several independent draw engines, e.g. scene redraw, stat-bar redraw and game sprite.
- Grants exclusive ownership for a whole draw job, from request until done, using round-robin selection.
- Muxes the owner's pixel stream to the adapter.
- Sits between the draw engines and the VGA adapter instance in the top level.

Parameters:
- NUM_REQ, 3, number of requesting draw engines (2..4).
- X_W, 8, x coordinate width (160x120 mode).
- Y_W, 7, y coordinate width.
- C_W, 8, colour width.
- MAX_HOLD, 19200, maximum cycles a grant may be held before forced release (one full 160x120 frame).

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-engine request, held high for the whole job.
- req_done  in  NUM_REQ  per-engine one-cycle pulse on the last pixel cycle of the job.
- req_x  in  NUM_REQ*X_W  packed x coordinates; engine i occupies bits [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  packed y coordinates, same packing.
- req_colour  in  NUM_REQ*C_W  packed colours, same packing.
- req_plot  in  NUM_REQ  per-engine plot strobe.
- grant  out  NUM_REQ  one-hot ownership; all zero when free.
- x  out  X_W  x coordinate to the VGA adapter.
- y  out  Y_W  y coordinate to the VGA adapter.
- colour  out  C_W  colour to the VGA adapter.
- writeEn  out  1  plot strobe to the VGA adapter.
- busy  out  1  high while any grant is active.
- owner  out  2  index of the current or most recent owner.
- timeout  out  1  sticky flag, set when a grant is force-released.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - grant=0, busy=0, owner=0, timeout=0.
  - Round-robin pointer rr=0.
  - Hold counter=0.
  - x/y/colour/writeEn read 0.
- FSM states: IDLE, OWN, RELEASE.
- IDLE:
  - If req!=0, select the first set bit searching rr, rr+1, … modulo NUM_REQ.
  - Register grant (one-hot), owner and busy=1; go to OWN.
  - Latency: req seen at cycle n, grant high at cycle n+1.
  - No req: remain in IDLE.
- OWN:
  - Datapath is combinational from registered state: x/y/colour = owner's slice; writeEn = req_plot[owner].
  - Non-owners' req_plot is ignored entirely; a non-owner pixel never reaches the adapter.
  - Hold counter increments every cycle.
- Exit from OWN to RELEASE, on whichever of these conditions occurs first:
  - req_done[owner]=1. The pixel plotted in that same cycle is still forwarded.
  - req[owner]=0 (abort); writeEn is forced to 0 in that cycle.
  - Hold counter reaches MAX_HOLD-1; timeout is set to 1 and stays set until reset.
- On entering RELEASE:
  - rr = (owner+1) mod NUM_REQ.
  - Hold counter cleared.
- RELEASE:
  - One dead cycle: grant=0, busy=0, writeEn=0, x/y/colour=0.
  - Go to IDLE unconditionally.
  - Earliest re-grant is 2 cycles after the done pulse.
  - Guarantees no back-to-back job overlap in the adapter.
- Outside OWN: writeEn=0 and x/y/colour=0.
- owner holds its last value in IDLE.
- Simultaneous events:
  - Multiple req in IDLE: round-robin order decides; no engine is starved. Every requester is granted within NUM_REQ jobs.
  - req_done pulse from a non-owner: ignored.
  - Done, abort and timeout in the same cycle: a single release; timeout is set only if the counter condition holds.
- req must stay high until grant; dropping it before grant simply withdraws the request.
- Reset mid-job: the job is dropped immediately and writeEn falls asynchronously.

Test Plan:
- Single request: reset, then req=3'b010 at cycle 5 → grant=3'b010 at cycle 6, busy=1, owner=1. Drive req_plot with x=8'd10, y=7'd20, colour=8'hE0 → identical outputs with writeEn=1. req_done pulse at cycle 12 → grant=0 at cycle 13, busy=0.
- Round-robin: req=3'b111 held, each job 4 cycles then done → grant sequence 001, 010, 100, 001. RELEASE cycle of grant=0 between each job.
- Isolation: owner=0 with req_plot[0]=0 while req_plot[2]=1 (x=8'd99) → writeEn=0, x=0, and engine 2 remains ungranted.
- Abort: owner=2, req[2] drops at cycle k → writeEn=0 at cycle k, grant=0 at cycle k+1, next grant goes to engine 0.
- Timeout (MAX_HOLD=16): grant held without done → forced release after 16 cycles, timeout=1. timeout stays 1 across later normal jobs until reset.
- Async reset mid-job: reset asserted mid-cycle during OWN → grant=0 and writeEn=0 immediately, before the next clk edge. After release, req=3'b100 → grant=3'b100 one cycle later (rr restarted at 0, but engines 0 and 1 are idle).
